damy_memory_param_be: RTL

DAMY_MEMORY_PARAM_BE -- requirements
Module: damy_memory_param_be

---
 rtl/damy_memory_param_be.sv | 119 +++++++++++
 1 files changed

// File: rtl/damy_memory_param_be.sv
// Byte-enabled single-port-per-direction memory with pipelined reads and a
// zero-fill sweep that runs after reset or on request.
module damy_memory_param_be #(
  parameter int P_DATA_W     = 256,
  parameter int P_ADDR_W     = 4,
  parameter int P_RD_LATENCY = 1
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic                  iCLEAR,
  output logic                  oBUSY,
  input  logic                  iWR_ENA,
  input  logic [P_ADDR_W-1:0]   iWR_ADDR,
  input  logic [P_DATA_W-1:0]   iWR_DATA,
  input  logic [P_DATA_W/8-1:0] iBYTE_ENA,
  input  logic                  iRD_REQ,
  input  logic [P_ADDR_W-1:0]   iRD_ADDR,
  output logic                  oRD_VALID,
  output logic [P_DATA_W-1:0]   oRD_DATA,
  output logic                  oREQ_REJECT
);

  localparam int DEPTH = 2 ** P_ADDR_W;
  localparam int NB    = P_DATA_W / 8;

  generate
    if (P_RD_LATENCY < 1 || P_RD_LATENCY > 4 || P_DATA_W < 8 || (P_DATA_W % 8) != 0) begin : g_param_err
      $fatal(1, "damy_memory_param_be: illegal P_RD_LATENCY or P_DATA_W");
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg, state_next;
  logic [P_ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic                busy, wr_accept, rd_accept, wr_hit;
  logic                reject_reg;

  logic [P_DATA_W-1:0] mem [DEPTH];
  logic [P_DATA_W-1:0] mem_rd, rd_merged;

  logic [P_RD_LATENCY-1:0] vld_reg;
  logic [P_DATA_W-1:0]     dat_reg [P_RD_LATENCY];

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (iCLEAR) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt_reg + P_ADDR_W'(1);
        if (clr_cnt_reg == '1) state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  assign busy      = (state_reg == CLEAR);
  assign wr_accept = !busy && iWR_ENA;
  assign rd_accept = !busy && iRD_REQ;
  assign wr_hit    = wr_accept && (iWR_ADDR == iRD_ADDR);

  // Sweep has priority; requests are never accepted while it runs anyway.
  always_ff @(posedge iCLOCK) begin
    if (busy) begin
      mem[clr_cnt_reg] <= '0;
    end else if (wr_accept) begin
      for (int k = 0; k < NB; k++) begin
        if (iBYTE_ENA[k]) mem[iWR_ADDR][8*k +: 8] <= iWR_DATA[8*k +: 8];
      end
    end
  end

  // Write-first bypass: the read sees the byte-merged value being written.
  assign mem_rd = mem[iRD_ADDR];
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign rd_merged[8*gi +: 8] = (wr_hit && iBYTE_ENA[gi]) ? iWR_DATA[8*gi +: 8]
                                                              : mem_rd[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      vld_reg    <= '0;
      reject_reg <= 1'b0;
      for (int i = 0; i < P_RD_LATENCY; i++) dat_reg[i] <= '0;
    end else begin
      vld_reg[0] <= rd_accept;
      dat_reg[0] <= rd_merged;
      for (int i = 1; i < P_RD_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        dat_reg[i] <= dat_reg[i-1];
      end
      reject_reg <= busy && (iWR_ENA || iRD_REQ);
    end
  end

  assign oBUSY       = busy;
  assign oRD_VALID   = vld_reg[P_RD_LATENCY-1];
  assign oRD_DATA    = vld_reg[P_RD_LATENCY-1] ? dat_reg[P_RD_LATENCY-1] : '0;
  assign oREQ_REJECT = reject_reg;

endmodule
